mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch stage and the MEM stage of the Chronos pipeline. The block has one outstanding transaction at a time. Priority is data-over-fetch, with a starvation guard so fetch still makes progress. The arbiter sequences each transaction through request, accept and response phases, and routes the response back to the requester that owns it. A fetch that the pipeline kills (branch mispredict) still completes on the memory side, but its response is silently dropped.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the MEM
//               stage. One outstanding transaction, data-over-fetch priority
//               with a starvation guard, response routing to the owner and
//               silent dropping of killed fetch responses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch side
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_gnt,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    // data (MEM stage) side
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rsp_valid,
    output logic [DATA_W-1:0]   dm_rsp_data,
    // memory side
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                busy
);

    localparam int                 C_BE_W  = DATA_W / 8;
    localparam int                 C_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_starve_cnt;
    logic                r_owner_dm;     // 0 = fetch owns the port, 1 = data
    logic                r_drop;         // fetch response must be swallowed
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [C_BE_W-1:0]   r_mem_be;
    logic                r_if_rsp_valid;
    logic [DATA_W-1:0]   r_if_rsp_data;
    logic                r_dm_rsp_valid;
    logic [DATA_W-1:0]   r_dm_rsp_data;

    logic                w_idle;
    logic                w_pick_if;
    logic                w_pick_dm;
    logic                w_if_killed;

    // Arbitration: data wins contention unless fetch has waited out the limit
    assign w_idle      = (r_state == S_IDLE);
    assign w_pick_if   = w_idle & if_req & (~dm_req | (r_starve_cnt == C_LIMIT));
    assign w_pick_dm   = w_idle & dm_req & ~w_pick_if;
    assign w_if_killed = if_kill & ~r_owner_dm;

    // Grants are decided combinationally in IDLE; suppressed while in reset
    assign if_gnt = rst & w_pick_if;
    assign dm_gnt = rst & w_pick_dm;

    assign mem_req      = (r_state == S_REQ);
    assign busy         = ~w_idle;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_be       = r_mem_be;
    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rsp_data  = r_if_rsp_data;
    assign dm_rsp_valid = r_dm_rsp_valid;
    assign dm_rsp_data  = r_dm_rsp_data;

    // Transaction sequencer: grant/latch, request phase, response routing
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_starve_cnt   <= '0;
            r_owner_dm     <= 1'b0;
            r_drop         <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_be       <= '0;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_dm_rsp_valid <= 1'b0;
            r_dm_rsp_data  <= '0;
        end else begin
            // responses are single-cycle pulses
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_dm_rsp_valid <= 1'b0;
            r_dm_rsp_data  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_if || w_pick_dm) begin
                        r_owner_dm <= w_pick_dm;
                        r_drop     <= w_pick_if & if_kill;
                        r_state    <= S_REQ;
                        if (w_pick_dm) begin
                            r_mem_we    <= dm_we;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                            r_mem_be    <= dm_be;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= if_addr;
                            r_mem_wdata <= '0;
                            r_mem_be    <= '0;
                        end
                        // count only data wins that left a fetch waiting
                        if (w_pick_if || !if_req) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != C_LIMIT) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    r_drop <= r_drop | w_if_killed;
                    if (mem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state <= S_IDLE;
                        r_drop  <= 1'b0;
                        if (r_owner_dm) begin
                            r_dm_rsp_valid <= 1'b1;
                            r_dm_rsp_data  <= r_mem_we ? '0 : mem_rsp_data;
                        end else if (!(r_drop || if_kill)) begin
                            r_if_rsp_valid <= 1'b1;
                            r_if_rsp_data  <= mem_rsp_data;
                        end
                    end else begin
                        r_drop <= r_drop | w_if_killed;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: vector table of
//               single transactions, hand-written contention / starvation /
//               reset sequences, and a random run against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int C_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_kill = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_gnt, dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(C_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rsp_valid(dm_rsp_valid),
        .dm_rsp_data(dm_rsp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // kill_at: 0 none, 1 grant cycle, 2 first REQ cycle, 3 first WAIT cycle,
    // 4 the mem_rsp_valid cycle
    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;
        int          kill_at;
        logic        exp_if_v;
        logic [31:0] exp_if_d;
        logic        exp_dm_v;
        logic [31:0] exp_dm_d;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " if_gnt"}, 32'(if_gnt), 0);
        chk({tag, " dm_gnt"}, 32'(dm_gnt), 0);
        chk({tag, " if_rsp_valid"}, 32'(if_rsp_valid), 0);
        chk({tag, " if_rsp_data"}, if_rsp_data, 0);
        chk({tag, " dm_rsp_valid"}, 32'(dm_rsp_valid), 0);
        chk({tag, " dm_rsp_data"}, dm_rsp_data, 0);
        chk({tag, " mem_req"}, 32'(mem_req), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " mem_be"}, 32'(mem_be), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    // One isolated transaction; entered and left just after a rising edge.
    task automatic run_txn(input vec_t v);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        if_kill = (v.kill_at == 1);
        #1;
        chk("vec if_gnt", 32'(if_gnt), 32'(!v.is_dm));
        chk("vec dm_gnt", 32'(dm_gnt), 32'(v.is_dm));
        chk("vec mem_req at grant", 32'(mem_req), 0);
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
        for (int k = 0; k <= v.rdy_dly; k++) begin
            mem_ready     = (k == v.rdy_dly);
            mem_rsp_valid = (k != v.rdy_dly);       // stray response, must be ignored
            mem_rsp_data  = 32'hBAD0_0000 | 32'(k);
            if_kill       = (v.kill_at == 2 && k == 0);
            #1;
            chk("req mem_req", 32'(mem_req), 1);
            chk("req busy", 32'(busy), 1);
            chk("req mem_addr", mem_addr, v.addr);
            chk("req mem_we", 32'(mem_we), 32'(v.is_dm & v.we));
            if (v.is_dm) begin
                chk("req mem_wdata", mem_wdata, v.wdata);
                chk("req mem_be", 32'(mem_be), 32'(v.be));
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        for (int k = 0; k <= v.rsp_dly; k++) begin
            mem_rsp_valid = (k == v.rsp_dly);
            mem_rsp_data  = (k == v.rsp_dly) ? v.rdata : 32'h0BAD_0000;
            if_kill       = (v.kill_at == 3 && k == 0) || (v.kill_at == 4 && k == v.rsp_dly);
            #1;
            chk("wait mem_req", 32'(mem_req), 0);
            chk("wait busy", 32'(busy), 1);
            chk("wait if_rsp_valid", 32'(if_rsp_valid), 0);
            chk("wait dm_rsp_valid", 32'(dm_rsp_valid), 0);
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0; if_kill = 1'b0;
        chk("rsp if_rsp_valid", 32'(if_rsp_valid), 32'(v.exp_if_v));
        if (v.exp_if_v) chk("rsp if_rsp_data", if_rsp_data, v.exp_if_d);
        chk("rsp dm_rsp_valid", 32'(dm_rsp_valid), 32'(v.exp_dm_v));
        if (v.exp_dm_v) chk("rsp dm_rsp_data", dm_rsp_data, v.exp_dm_d);
        chk("rsp busy", 32'(busy), 0);
    endtask

    // Serve a just-granted transaction with 1-cycle memory latencies.
    task automatic serve(input logic clr_if, input logic clr_dm, input logic [31:0] rd);
        @(posedge clk); #1;
        if (clr_if) if_req = 1'b0;
        if (clr_dm) dm_req = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = rd;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
    endtask

    // Random-run transaction model
    bit          if_pend, dm_pend, t_active, t_sent, t_dm, t_we, t_drop;
    bit          gi, gd, was_active, was_req;
    logic [31:0] if_a, dm_a, dm_wd, t_addr, t_wd;
    logic [3:0]  dm_b, t_be;
    logic        dm_w;
    int          streak;
    logic        e_ifv, e_dmv;
    logic [31:0] e_ifd, e_dmd;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0000_0013, 0, 0, 0, 1'b1, 32'h0000_0013, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 3, 0, 0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 2, 0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 32'h0000_0055, 0, 2, 3, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 32'h00A0_0093, 0, 1, 0, 1'b1, 32'h00A0_0093, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 32'h1111_1111, 0, 0, 1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h304, 32'h0, 4'h0, 32'h2222_2222, 2, 0, 2, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h308, 32'h0, 4'h0, 32'h3333_3333, 0, 1, 4, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h4000, 32'h0, 4'h0, 32'h4444_4444, 0, 1, 3, 1'b0, 32'h0, 1'b1, 32'h4444_4444};
        vecs[9] = '{1'b1, 1'b1, 32'h44, 32'h0000_BEEF, 4'h3, 32'h5555_5555, 1, 3, 0, 1'b0, 32'h0, 1'b1, 32'h0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // vector table
        foreach (vecs[i]) run_txn(vecs[i]);

        // contention: data first, fetch at the next decision after dm_req drops
        if_req = 1'b1; if_addr = 32'h500;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        #1;
        chk("contend dm_gnt", 32'(dm_gnt), 1);
        chk("contend if_gnt", 32'(if_gnt), 0);
        serve(1'b0, 1'b1, 32'h7777_0001);
        chk("contend dm_rsp", 32'(dm_rsp_valid), 1);
        chk("contend dm_data", dm_rsp_data, 32'h7777_0001);
        #1;
        chk("contend if_gnt 2nd", 32'(if_gnt), 1);
        serve(1'b1, 1'b0, 32'h7777_0002);
        chk("contend if_rsp", 32'(if_rsp_valid), 1);
        chk("contend if_data", if_rsp_data, 32'h7777_0002);

        // starvation guard: D,D,D,D,I repeated
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve if_gnt", 32'(if_gnt), 32'(i % 5 == 4));
            chk("starve dm_gnt", 32'(dm_gnt), 32'(i % 5 != 4));
            serve(i == 9, i == 9, 32'(i));
            chk("starve rsp owner", 32'(if_rsp_valid), 32'(i % 5 == 4));
        end

        // reset mid-WAIT, then a stray response in IDLE
        if_req = 1'b1; if_addr = 32'h180;
        #1;
        chk("rstwait if_gnt", 32'(if_gnt), 1);
        @(posedge clk); #1;
        if_req = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk_all_zero("rstwait");
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk("stray if_rsp_valid", 32'(if_rsp_valid), 0);
        chk("stray dm_rsp_valid", 32'(dm_rsp_valid), 0);
        chk("stray busy", 32'(busy), 0);
        run_txn(vecs[2]);

        // random run against the transaction model
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        if_pend = 0; dm_pend = 0; t_active = 0; t_sent = 0; t_drop = 0;
        streak = 0; e_ifv = 0; e_dmv = 0; e_ifd = '0; e_dmd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            chk("rnd if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
            if (e_ifv) chk("rnd if_rsp_data", if_rsp_data, e_ifd);
            chk("rnd dm_rsp_valid", 32'(dm_rsp_valid), 32'(e_dmv));
            if (e_dmv) chk("rnd dm_rsp_data", dm_rsp_data, e_dmd);
            e_ifv = 0; e_dmv = 0;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_a = $urandom;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1; dm_a = $urandom; dm_wd = $urandom;
                dm_w = 1'($urandom_range(0, 1)); dm_b = 4'($urandom_range(0, 15));
            end
            if_req = if_pend; if_addr = if_a;
            dm_req = dm_pend; dm_addr = dm_a; dm_wdata = dm_wd; dm_we = dm_w; dm_be = dm_b;
            mem_ready     = 1'($urandom_range(0, 1));
            mem_rsp_valid = ($urandom_range(0, 2) == 0);
            mem_rsp_data  = $urandom;
            if_kill       = ($urandom_range(0, 7) == 0);
            #1;
            was_active = t_active;
            was_req    = t_active && !t_sent;
            gi = 0; gd = 0;
            if (!t_active) begin
                if (if_pend || dm_pend) begin
                    gi = if_pend && (!dm_pend || streak == C_LIMIT);
                    gd = !gi;
                    streak = (gi || !if_pend) ? 0 : ((streak < C_LIMIT) ? streak + 1 : C_LIMIT);
                    t_active = 1; t_sent = 0; t_dm = gd;
                    t_we   = gd ? dm_w : 1'b0;
                    t_addr = gd ? dm_a : if_a;
                    t_wd   = dm_wd; t_be = dm_b;
                    t_drop = gi && if_kill;
                end
            end else if (!t_sent) begin
                chk("rnd mem_addr", mem_addr, t_addr);
                chk("rnd mem_we", 32'(mem_we), 32'(t_we));
                if (t_dm) begin
                    chk("rnd mem_wdata", mem_wdata, t_wd);
                    chk("rnd mem_be", 32'(mem_be), 32'(t_be));
                end
                if (!t_dm && if_kill) t_drop = 1;
                if (mem_ready) t_sent = 1;
            end else begin
                if (!t_dm && if_kill) t_drop = 1;
                if (mem_rsp_valid) begin
                    t_active = 0;
                    if (t_dm) begin
                        e_dmv = 1; e_dmd = t_we ? 32'h0 : mem_rsp_data;
                    end else if (!t_drop) begin
                        e_ifv = 1; e_ifd = mem_rsp_data;
                    end
                end
            end
            chk("rnd if_gnt", 32'(if_gnt), 32'(gi));
            chk("rnd dm_gnt", 32'(dm_gnt), 32'(gd));
            chk("rnd busy", 32'(busy), 32'(was_active));
            chk("rnd mem_req", 32'(mem_req), 32'(was_req));
            if (gi) if_pend = 0;
            if (gd) dm_pend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
